gcd_serial_bridge: RTL and testbench
====================================

// Module: gcd_serial_bridge
// PURPOSE
//  Pad-side bridge for the gcd core. Assembles the 32-bit GCD request from a 1-bit serial
//  pad stream and drives the core's req val/rdy handshake. Captures the 16-bit response via
//  resp val/rdy and shifts it back out on one pad. Sits between the pad cells and gcd.
// PARAMETERS
//  REQ_W   32  request word width (bits shifted in per frame)
//  RESP_W  16  response word width (bits shifted out per frame)
// PORTS
//  clk            in   1       core clock (from clock pad)
//  reset          in   1       synchronous, active-high reset
//  ser_in_data    in   1       serial request bit, MSB first
//  ser_in_valid   in   1       ser_in_data sampled this cycle
//  ser_in_clr     in   1       abort partial RX frame; bit counter -> 0
//  ser_in_busy    out  1       1 = RX holding a full word; incoming bits ignored
//  req_msg        out  REQ_W   assembled request to gcd
//  req_val        out  1       request valid to gcd
//  req_rdy        in   1       gcd ready
//  resp_msg       in   RESP_W  result from gcd
//  resp_val       in   1       gcd result valid
//  resp_rdy       out  1       bridge ready to capture result
//  ser_out_en     in   1       pad side accepts one bit this cycle (TX advance)
//  ser_out_data   out  1       serial response bit, MSB first
//  ser_out_valid  out  1       ser_out_data meaningful
//  ser_out_last   out  1       final bit of TX frame
//  par_err        out  1       one-cycle pulse: RX parity mismatch (0 without macro)
// BEHAVIOUR
//  Reset: RX=RX_SHIFT, TX=TX_IDLE, counters 0, req_msg=0, req_val=0, ser_in_busy=0,
//   resp_rdy=1, ser_out_data/valid/last=0, par_err=0. Reset mid-frame discards everything.
//  RX FSM RX_SHIFT -> [RX_PAR] -> RX_HOLD -> RX_SHIFT:
//   - RX_SHIFT: ser_in_valid=1 -> shreg <= {shreg[REQ_W-2:0], ser_in_data}, cnt++.
//     On the REQ_W-th bit go RX_HOLD (RX_PAR if PARITY_EN); cnt -> 0.
//   - RX_HOLD: req_val=1, req_msg stable, ser_in_busy=1. On req_val&&req_rdy
//     -> RX_SHIFT next cycle; req_val drops same edge. Bits in HOLD are dropped.
//   - Min latency: req_val rises the cycle after last data bit (parity bit) is sampled.
//   - ser_in_clr: in RX_SHIFT/RX_PAR clears cnt and returns RX_SHIFT; wins over
//     simultaneous ser_in_valid. Ignored in RX_HOLD (held word is never lost).
//  TX FSM TX_IDLE -> TX_SHIFT -> TX_IDLE:
//   - TX_IDLE: resp_rdy=1. resp_val&&resp_rdy -> latch resp_msg, cnt=0, go TX_SHIFT.
//   - TX_SHIFT: resp_rdy=0, ser_out_valid=1, ser_out_data=current MSB of latch.
//     Shift/cnt++ only on cycles with ser_out_en=1; held otherwise.
//   - ser_out_last=1 while presenting final bit (bit 0, or parity bit if PARITY_EN).
//     ser_out_en with ser_out_last -> TX_IDLE; resp_rdy=1 from next cycle.
//   - Back-to-back: a new response can be captured the cycle after return to IDLE.
//  RX and TX fully independent; concurrent activity allowed every cycle.
//  Counters sized $clog2(W+1); no wrap: cnt cleared on every frame completion.
// CONFIGURATION
//  GCD_SERIAL_PARITY_EN defined:
//   - RX: one extra bit after REQ_W data bits = odd parity over data. Mismatch ->
//     word discarded, par_err=1 one cycle, RX_SHIFT; match -> RX_HOLD.
//   - TX: extra final bit = ~^latched_word (odd parity) after RESP_W data bits.
//  Not defined: no parity bit either direction; frames exactly REQ_W / RESP_W bits;
//   par_err tied 0.
// TESTING
//  1 Reset: assert reset 2 cycles mid-RX frame (10 bits in) -> all outputs at reset
//    values; then full 32-bit frame 0x0030_0012 -> req_msg=0x00300012, req_val=1.
//  2 Handshake: hold req_rdy=0 5 cycles, stream extra bits -> req_msg unchanged,
//    ser_in_busy=1; req_rdy=1 -> req_val low next cycle, next frame assembles cleanly.
//  3 ser_in_clr after 7 bits, simultaneous with valid bit -> bit dropped; new 32 bits
//    0xDEAD_BEEF -> req_msg=0xDEADBEEF.
//  4 TX: resp_msg=0x8001, resp_val=1, ser_out_en toggling 1/0 -> bits
//    1,0..0,1 only on en cycles, ser_out_last on 16th, resp_rdy back after.
//  5 GCD_SERIAL_PARITY_EN: RX 0x0000_0001 + parity 0 -> RX_HOLD; parity 1 ->
//    par_err pulse, no req_val. TX 0x0003 -> 17th bit = 1.
//  6 Concurrency: RX frame and TX frame overlapping same cycles -> both correct.

Source files
------------

// File: rtl/gcd_serial_bridge.sv
// Pad-side serial bridge for the gcd core: serial request in, val/rdy both ways, serial response out.
// Optional odd-parity framing on both directions when GCD_SERIAL_PARITY_EN is defined.
//   state    | meaning
//   RX_SHIFT | collecting request data bits
//   RX_PAR   | waiting for the request parity bit
//   RX_HOLD  | full request presented to gcd, incoming bits dropped
//   TX_IDLE  | ready to capture a response
//   TX_SHIFT | presenting response bits to the pad
module gcd_serial_bridge #(
    parameter int REQ_W  = 32,
    parameter int RESP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_in_data,
    input  logic              ser_in_valid,
    input  logic              ser_in_clr,
    output logic              ser_in_busy,
    output logic [REQ_W-1:0]  req_msg,
    output logic              req_val,
    input  logic              req_rdy,
    input  logic [RESP_W-1:0] resp_msg,
    input  logic              resp_val,
    output logic              resp_rdy,
    input  logic              ser_out_en,
    output logic              ser_out_data,
    output logic              ser_out_valid,
    output logic              ser_out_last,
    output logic              par_err
);
    localparam int RX_CNT_W = $clog2(REQ_W + 1);
    localparam int TX_CNT_W = $clog2(RESP_W + 1);
`ifdef GCD_SERIAL_PARITY_EN
    localparam int TX_BITS = RESP_W + 1;
`else
    localparam int TX_BITS = RESP_W;
`endif
    localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(REQ_W - 1);
    localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(TX_BITS - 1);

    typedef enum logic [1:0] {RX_SHIFT, RX_PAR, RX_HOLD} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    rx_state_t           rx_state, rx_state_nxt;
    logic [RX_CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [REQ_W-1:0]    rx_shreg, rx_shreg_nxt;
    tx_state_t           tx_state, tx_state_nxt;
    logic [TX_CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [RESP_W-1:0]   tx_latch, tx_latch_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_SHIFT;
            rx_cnt   <= '0;
            rx_shreg <= '0;
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_latch <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_shreg <= rx_shreg_nxt;
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_latch <= tx_latch_nxt;
        end
    end

`ifdef GCD_SERIAL_PARITY_EN
    logic rx_par_bad;
    logic par_err_q;
    logic tx_par, tx_par_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_q <= 1'b0;
            tx_par    <= 1'b0;
        end else begin
            par_err_q <= rx_par_bad;
            tx_par    <= tx_par_nxt;
        end
    end
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_shreg_nxt = rx_shreg;
`ifdef GCD_SERIAL_PARITY_EN
        rx_par_bad   = 1'b0;
`endif
        case (rx_state)
            RX_SHIFT: begin
                if (ser_in_clr) begin
                    rx_cnt_nxt = '0;
                end else if (ser_in_valid) begin
                    rx_shreg_nxt = {rx_shreg[REQ_W-2:0], ser_in_data};
                    if (rx_cnt == RX_LAST) begin
                        rx_cnt_nxt = '0;
`ifdef GCD_SERIAL_PARITY_EN
                        rx_state_nxt = RX_PAR;
`else
                        rx_state_nxt = RX_HOLD;
`endif
                    end else begin
                        rx_cnt_nxt = rx_cnt + 1'b1;
                    end
                end
            end
`ifdef GCD_SERIAL_PARITY_EN
            RX_PAR: begin
                // Odd parity: data plus parity bit carries an odd number of ones.
                if (ser_in_clr) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_SHIFT;
                end else if (ser_in_valid) begin
                    if (ser_in_data == ~^rx_shreg) begin
                        rx_state_nxt = RX_HOLD;
                    end else begin
                        rx_state_nxt = RX_SHIFT;
                        rx_par_bad   = 1'b1;
                    end
                end
            end
`endif
            RX_HOLD: begin
                if (req_rdy) rx_state_nxt = RX_SHIFT;
            end
            default: begin
                rx_state_nxt = RX_SHIFT;
                rx_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_latch_nxt = tx_latch;
`ifdef GCD_SERIAL_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                if (resp_val) begin
                    tx_latch_nxt = resp_msg;
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_SHIFT;
`ifdef GCD_SERIAL_PARITY_EN
                    tx_par_nxt   = ~^resp_msg;
`endif
                end
            end
            TX_SHIFT: begin
                if (ser_out_en) begin
                    if (tx_cnt == TX_LAST) begin
                        tx_cnt_nxt   = '0;
                        tx_state_nxt = TX_IDLE;
                    end else begin
                        tx_cnt_nxt   = tx_cnt + 1'b1;
                        tx_latch_nxt = {tx_latch[RESP_W-2:0], 1'b0};
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    logic tx_bit;
`ifdef GCD_SERIAL_PARITY_EN
    assign tx_bit = (tx_cnt == TX_CNT_W'(RESP_W)) ? tx_par : tx_latch[RESP_W-1];
`else
    assign tx_bit = tx_latch[RESP_W-1];
`endif

    assign req_msg       = rx_shreg;
    assign req_val       = (rx_state == RX_HOLD);
    assign ser_in_busy   = (rx_state == RX_HOLD);
    assign resp_rdy      = (tx_state == TX_IDLE);
    assign ser_out_valid = (tx_state == TX_SHIFT);
    assign ser_out_data  = (tx_state == TX_SHIFT) && tx_bit;
    assign ser_out_last  = (tx_state == TX_SHIFT) && (tx_cnt == TX_LAST);
endmodule

// File: tb/tb_gcd_serial_bridge.sv
// Randomized bench for gcd_serial_bridge against a bit-queue reference of the serial frames.
// Build with GCD_SERIAL_PARITY_EN defined to exercise the parity framing.
module tb_gcd_serial_bridge;
    localparam int REQ_W  = 32;
    localparam int RESP_W = 16;
`ifdef GCD_SERIAL_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ser_in_data = 1'b0, ser_in_valid = 1'b0, ser_in_clr = 1'b0;
    logic              ser_in_busy;
    logic [REQ_W-1:0]  req_msg;
    logic              req_val;
    logic              req_rdy = 1'b0;
    logic [RESP_W-1:0] resp_msg = '0;
    logic              resp_val = 1'b0;
    logic              resp_rdy;
    logic              ser_out_en = 1'b0;
    logic              ser_out_data, ser_out_valid, ser_out_last;
    logic              par_err;

    int n_checks = 0;
    int n_fails  = 0;

    gcd_serial_bridge #(.REQ_W(REQ_W), .RESP_W(RESP_W)) dut (
        .clk(clk), .reset(reset),
        .ser_in_data(ser_in_data), .ser_in_valid(ser_in_valid), .ser_in_clr(ser_in_clr),
        .ser_in_busy(ser_in_busy), .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
        .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .ser_out_en(ser_out_en), .ser_out_data(ser_out_data), .ser_out_valid(ser_out_valid),
        .ser_out_last(ser_out_last), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_val"}, 32'(req_val), 32'd0);
        check({tag, "_req_msg"}, req_msg, 32'd0);
        check({tag, "_busy"}, 32'(ser_in_busy), 32'd0);
        check({tag, "_resp_rdy"}, 32'(resp_rdy), 32'd1);
        check({tag, "_out_data"}, 32'(ser_out_data), 32'd0);
        check({tag, "_out_valid"}, 32'(ser_out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(ser_out_last), 32'd0);
        check({tag, "_par_err"}, 32'(par_err), 32'd0);
    endtask

    // Streams one request frame (MSB first, optional odd-parity bit) and checks the outcome.
    task automatic rx_frame(input logic [31:0] word, input bit bad_par, input bit bubbles);
        bit q[$];
        int idx = 0;
        int guard = 0;
        bit p;
        for (int i = REQ_W - 1; i >= 0; i--) q.push_back(word[i]);
        if (PAR_EN) begin
            p = ~^word;
            q.push_back(bad_par ? ~p : p);
        end
        while (idx < q.size() && guard < 400) begin
            ser_in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            ser_in_data  = ser_in_valid ? q[idx] : 1'($urandom);
            tick();
            if (ser_in_valid) idx++;
            guard++;
            if (idx == q.size() - 1) check("rx_val_early", 32'(req_val), 32'd0);
        end
        ser_in_valid = 1'b0;
        check("rx_frame_done", idx, q.size());
        if (!bad_par) begin
            check("rx_req_val", 32'(req_val), 32'd1);
            check("rx_req_msg", req_msg, word);
            check("rx_busy", 32'(ser_in_busy), 32'd1);
        end else begin
            check("rx_bad_no_val", 32'(req_val), 32'd0);
            check("rx_par_err", 32'(par_err), 32'd1);
            tick();
            check("rx_par_err_pulse", 32'(par_err), 32'd0);
            check("rx_bad_still_no_val", 32'(req_val), 32'd0);
        end
    endtask

    task automatic release_req();
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        check("rel_req_val", 32'(req_val), 32'd0);
        check("rel_busy", 32'(ser_in_busy), 32'd0);
    endtask

    // Captures one response and checks every serial bit; toggle=1 drives en 1,0,1,0...
    task automatic tx_frame(input logic [15:0] word, input bit toggle);
        bit q[$];
        int idx = 0;
        int cyc = 0;
        int guard = 0;
        while (!resp_rdy && guard < 100) begin
            tick();
            guard++;
        end
        check("tx_rdy_before", 32'(resp_rdy), 32'd1);
        for (int i = RESP_W - 1; i >= 0; i--) q.push_back(word[i]);
        if (PAR_EN) q.push_back(~^word);
        resp_msg = word;
        resp_val = 1'b1;
        tick();
        resp_val = 1'b0;
        resp_msg = 16'($urandom);
        while (idx < q.size() && cyc < 300) begin
            ser_out_en = toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            check("tx_valid", 32'(ser_out_valid), 32'd1);
            check("tx_data", 32'(ser_out_data), 32'(q[idx]));
            check("tx_last", 32'(ser_out_last), 32'(idx == q.size() - 1));
            check("tx_rdy_busy", 32'(resp_rdy), 32'd0);
            tick();
            if (ser_out_en) idx++;
            cyc++;
        end
        ser_out_en = 1'b0;
        check("tx_frame_done", idx, q.size());
        check("tx_rdy_after", 32'(resp_rdy), 32'd1);
        check("tx_valid_after", 32'(ser_out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        repeat (2) tick();
        reset = 1'b0;
        check_reset_outputs("por");

        // Reset mid-frame discards the 10 partial bits.
        ser_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ser_in_data = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        repeat (2) tick();
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        ser_in_valid = 1'b0;
        tick();
        check_reset_outputs("post_rst");
        rx_frame(32'h0030_0012, 1'b0, 1'b0);

        // Held word survives stalled handshake, extra bits and a clear.
        held = req_msg;
        for (int i = 0; i < 5; i++) begin
            ser_in_valid = 1'b1;
            ser_in_data  = 1'($urandom);
            ser_in_clr   = (i == 2);
            tick();
            check("hold_msg", req_msg, held);
            check("hold_busy", 32'(ser_in_busy), 32'd1);
        end
        ser_in_valid = 1'b0;
        ser_in_clr   = 1'b0;
        release_req();
        rx_frame($urandom, 1'b0, 1'b0);
        release_req();

        // Clear after 7 bits, together with a valid bit.
        ser_in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ser_in_data = 1'($urandom);
            tick();
        end
        ser_in_clr  = 1'b1;
        ser_in_data = 1'b1;
        tick();
        ser_in_clr   = 1'b0;
        ser_in_valid = 1'b0;
        check("clr_no_val", 32'(req_val), 32'd0);
        rx_frame(32'hDEAD_BEEF, 1'b0, 1'b0);
        release_req();

        tx_frame(16'h8001, 1'b1);
        tx_frame(16'h0003, 1'b1);

        if (PAR_EN) begin
            rx_frame(32'h0000_0001, 1'b0, 1'b0);
            release_req();
            rx_frame(32'h0000_0001, 1'b1, 1'b0);
        end

        // Overlapping random RX and TX frames.
        for (int n = 0; n < 8; n++) begin
            fork
                rx_frame($urandom, PAR_EN && ($urandom_range(0, 2) == 0), 1'b1);
                tx_frame(16'($urandom), 1'b0);
            join
            if (req_val) release_req();
            check("conc_par_err_idle", 32'(par_err), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
